voq_req_gen: RTL and testbench

- Input-port side of the N×N crossbar scheduler: the initiator that feeds the priority scheduler and consumes its decisions.
- Keeps per-(input,output) virtual-output-queue (VOQ) occupancy counters from cell arrivals.
- Builds a registered priority request matrix, pulses start, then waits for the decision matrix.
- Validates the decision and converts each grant into a per-input dequeue command for the cell buffers.

---
 rtl/voq_pkg.sv | 17 +
 rtl/voq_cell.sv | 59 +++++
 rtl/voq_req_gen.sv | 177 +++++++++++++++++
 tb/tb_voq_req_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voq_pkg.sv
// Shared types for the VOQ request generator: FSM states, priority type and
// the at-most-one-hot check used when validating scheduler decisions.
package voq_pkg;

    localparam int P_DEF = 16;
    localparam int MAXN  = 32;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, APPLY} state_t;

    typedef logic [$clog2(P_DEF)-1:0] pri_t;

    // Callers zero-extend narrower vectors into the MAXN-wide argument.
    function automatic logic onehot_le1(input logic [MAXN-1:0] v);
        return (v & (v - MAXN'(1))) == '0;
    endfunction

endpackage

// File: rtl/voq_cell.sv
// One virtual output queue: cell count, starvation age and the priority it
// would request if a round started now.
module voq_cell #(
    parameter int  P          = 16,
    parameter int  DEPTH      = 15,
    parameter int  STARVE_LIM = 8,
    localparam int W          = $clog2(P),
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int AW         = $clog2(STARVE_LIM + 1)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    input  logic         i_round_end,
    input  logic         i_grant,
    output logic         o_full,
    output logic         o_nonempty,
    output logic [W-1:0] o_pri
);

    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_age;
    logic          w_inc;
    logic          w_dec;

    assign o_full     = (r_cnt == CW'(DEPTH));
    assign o_nonempty = (r_cnt != '0);
    assign w_inc      = i_inc & ~o_full;
    assign w_dec      = i_round_end & i_grant & o_nonempty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_age <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(w_inc) - CW'(w_dec);
            // A round that ends without serving a waiting queue ages it.
            if (i_round_end) begin
                if (!o_nonempty || i_grant)
                    r_age <= '0;
                else if (r_age != AW'(STARVE_LIM))
                    r_age <= r_age + AW'(1);
            end
        end
    end

    always_comb begin
        o_pri = '0;
        if (!o_nonempty)
            o_pri = '0;
        else if (r_age >= AW'(STARVE_LIM))
            o_pri = W'(P - 1);
        else if (int'(r_cnt) >= P - 1)
            o_pri = W'(P - 1);
        else
            o_pri = W'(r_cnt);
    end

endmodule

// File: rtl/voq_req_gen.sv
// Input-side VOQ request generator: tracks per-(input,output) occupancy, issues a
// priority request round to the scheduler and turns its grants into dequeues.
module voq_req_gen
    import voq_pkg::*;
#(
    parameter int  N          = 4,
    parameter int  P          = 16,
    parameter int  DEPTH      = 15,
    parameter int  STARVE_LIM = 8,
    parameter int  TIMEOUT    = 64,
    localparam int NW         = $clog2(N),
    localparam int W          = $clog2(P),
    localparam int TW         = $clog2(TIMEOUT + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [N-1:0]                   i_arr_valid,
    input  logic [N-1:0][NW-1:0]           i_arr_dest,
    output logic [N-1:0]                   o_arr_ready,
    output logic                           o_start,
    output logic [0:N-1][0:N-1][W-1:0]     o_pri_req,
    input  logic [N-1:0][N-1:0]            i_decision,
    input  logic                           i_decision_valid,
    output logic [N-1:0]                   o_deq_valid,
    output logic [N-1:0][NW-1:0]           o_deq_dest,
    output logic                           o_proto_err,
    output logic                           o_timeout_err
);

    state_t                        r_state;
    logic [TW-1:0]                 r_wcnt;
    logic                          r_start;
    logic [0:N-1][0:N-1][W-1:0]    r_pri;
    logic [N-1:0][N-1:0]           r_dec;
    logic [N-1:0][N-1:0]           r_grant;
    logic [N-1:0]                  r_deq_valid;
    logic [N-1:0][NW-1:0]          r_deq_dest;
    logic                          r_proto;
    logic                          r_tmo;

    logic [N-1:0][N-1:0]           w_full;
    logic [N-1:0][N-1:0]           w_nonempty;
    logic [0:N-1][0:N-1][W-1:0]    w_pri;
    logic [N-1:0][N-1:0]           w_colv;
    logic                          w_illegal;
    logic                          w_any;
    logic                          w_apply;
    logic                          w_timeout;
    logic                          w_round_end;
    logic [N-1:0]                  w_deq_v;
    logic [N-1:0][NW-1:0]          w_deq_d;

    assign w_any       = |w_nonempty;
    assign w_apply     = (r_state == APPLY);
    assign w_timeout   = (r_state == WAIT) && !i_decision_valid &&
                         (r_wcnt == TW'(TIMEOUT - 1));
    assign w_round_end = w_apply | w_timeout;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            voq_cell #(
                .P          (P),
                .DEPTH      (DEPTH),
                .STARVE_LIM (STARVE_LIM)
            ) u_cell (
                .i_clk       (i_clk),
                .i_reset     (i_reset),
                .i_inc       (i_arr_valid[gi] && (i_arr_dest[gi] == NW'(gj))),
                .i_round_end (w_round_end),
                .i_grant     (w_apply && r_grant[gi][gj]),
                .o_full      (w_full[gi][gj]),
                .o_nonempty  (w_nonempty[gi][gj]),
                .o_pri       (w_pri[gi][gj])
            );
        end
        // Full means full even if this cycle also dequeues from that VOQ.
        assign o_arr_ready[gi] = ~w_full[gi][i_arr_dest[gi]];
    end

    // Grants must be a partial permutation and only land on requested VOQs.
    always_comb begin
        w_illegal = 1'b0;
        w_colv    = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_colv[j][i] = r_dec[i][j];
                if (r_dec[i][j] && (r_pri[i][j] == '0))
                    w_illegal = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!onehot_le1(MAXN'(r_dec[k])) || !onehot_le1(MAXN'(w_colv[k])))
                w_illegal = 1'b1;
        end
    end

    always_comb begin
        w_deq_v = '0;
        w_deq_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (r_grant[i][j] && w_nonempty[i][j]) begin
                    w_deq_v[i] = 1'b1;
                    w_deq_d[i] = NW'(j);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_wcnt      <= '0;
            r_start     <= 1'b0;
            r_pri       <= '0;
            r_dec       <= '0;
            r_grant     <= '0;
            r_deq_valid <= '0;
            r_deq_dest  <= '0;
            r_proto     <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_start     <= 1'b0;
            r_proto     <= 1'b0;
            r_tmo       <= 1'b0;
            r_deq_valid <= '0;
            r_deq_dest  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_pri   <= w_pri;
                        r_start <= 1'b1;
                        r_wcnt  <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_decision_valid) begin
                        r_dec   <= i_decision;
                        r_state <= CHECK;
                    end else if (w_timeout) begin
                        r_tmo   <= 1'b1;
                        r_pri   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_wcnt  <= r_wcnt + TW'(1);
                    end
                end
                CHECK: begin
                    if (w_illegal) begin
                        r_proto <= 1'b1;
                        r_grant <= '0;
                    end else begin
                        r_grant <= r_dec;
                    end
                    r_state <= APPLY;
                end
                APPLY: begin
                    r_deq_valid <= w_deq_v;
                    r_deq_dest  <= w_deq_d;
                    r_pri       <= '0;
                    r_grant     <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_start       = r_start;
    assign o_pri_req     = r_pri;
    assign o_deq_valid   = r_deq_valid;
    assign o_deq_dest    = r_deq_dest;
    assign o_proto_err   = r_proto;
    assign o_timeout_err = r_tmo;

endmodule

// File: tb/tb_voq_req_gen.sv
// Directed scoreboard bench for voq_req_gen: the stimulus queues expected
// events, a negedge monitor pops and compares each DUT output event.
module tb_voq_req_gen;

    localparam int N       = 4;
    localparam int K_START = 0;
    localparam int K_DEQ   = 1;
    localparam int K_PROTO = 2;
    localparam int K_TMO   = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N-1:0]               arr_valid;
    logic [N-1:0][1:0]          arr_dest;
    logic [N-1:0]               arr_ready;
    logic                       start;
    logic [0:N-1][0:N-1][3:0]   pri_req;
    logic [N-1:0][N-1:0]        decision;
    logic                       decision_valid;
    logic [N-1:0]               deq_valid;
    logic [N-1:0][1:0]          deq_dest;
    logic                       proto_err;
    logic                       timeout_err;

    typedef struct {
        int          kind;
        logic [63:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;

    always #5 clk = ~clk;

    voq_req_gen u_dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_arr_valid      (arr_valid),
        .i_arr_dest       (arr_dest),
        .o_arr_ready      (arr_ready),
        .o_start          (start),
        .o_pri_req        (pri_req),
        .i_decision       (decision),
        .i_decision_valid (decision_valid),
        .o_deq_valid      (deq_valid),
        .o_deq_dest       (deq_dest),
        .o_proto_err      (proto_err),
        .o_timeout_err    (timeout_err)
    );

    function automatic logic [63:0] pm(input int i, input int j, input int v);
        logic [0:N-1][0:N-1][3:0] m;
        m       = '0;
        m[i][j] = 4'(v);
        return m;
    endfunction

    function automatic logic [N-1:0][N-1:0] gm(input int i, input int j);
        logic [N-1:0][N-1:0] g;
        g       = '0;
        g[i][j] = 1'b1;
        return g;
    endfunction

    function automatic logic [63:0] dq(input logic [3:0] v, input logic [7:0] d);
        return {52'b0, v, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_ev(input int k, input logic [63:0] d, input string name);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_%s: got data %0h, expected no event", name, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                n_errors++;
                $display("FAIL event_%s: got kind %0d data %0h, expected kind %0d data %0h",
                         name, k, d, e.kind, e.data);
            end
        end
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL start_wait: got no start in 150 cycles, expected one");
        end
    endtask

    task automatic wait_timeout();
        bit seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL timeout_wait: got no timeout_err in 150 cycles, expected one");
        end
    endtask

    // Called at the negedge of a start cycle; returns at the following negedge.
    task automatic decide(input logic [N-1:0][N-1:0] d);
        decision       = d;
        decision_valid = 1'b1;
        @(negedge clk);
        decision_valid = 1'b0;
        decision       = '0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_start"},   64'(start),       64'd0);
        chk({tag, "_pri"},     pri_req,          64'd0);
        chk({tag, "_deqv"},    64'(deq_valid),   64'd0);
        chk({tag, "_deqd"},    64'(deq_dest),    64'd0);
        chk({tag, "_proto"},   64'(proto_err),   64'd0);
        chk({tag, "_tmo"},     64'(timeout_err), 64'd0);
        chk({tag, "_ready"},   64'(arr_ready),   64'hf);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (proto_err === 1'b1)   chk_ev(K_PROTO, 64'd0, "proto");
                if (timeout_err === 1'b1) chk_ev(K_TMO, 64'd0, "timeout");
                if (deq_valid !== '0)     chk_ev(K_DEQ, dq(deq_valid, deq_dest), "deq");
                if (start === 1'b1)       chk_ev(K_START, pri_req, "start");
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset          = 1'b1;
        arr_valid      = '0;
        arr_dest       = '0;
        decision       = '0;
        decision_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("rst");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Three arrivals to [0][2]; first round snapshots count 1, then times out.
        expect_ev(K_START, pm(0, 2, 1));
        expect_ev(K_TMO, 64'd0);
        expect_ev(K_START, pm(0, 2, 3));
        arr_valid[0] = 1'b1;
        arr_dest[0]  = 2'd2;
        @(negedge clk);
        chk("lat_early", 64'(start), 64'd0);
        @(negedge clk);
        chk("lat_start", 64'(start), 64'd1);
        @(negedge clk);
        arr_valid[0] = 1'b0;
        wait_timeout();
        @(negedge clk);
        chk("tmo_restart", 64'(start), 64'd1);

        // Legal grant on [0][2].
        expect_ev(K_DEQ, dq(4'b0001, 8'h02));
        expect_ev(K_START, pm(0, 2, 2));
        decide(gm(0, 2));
        @(negedge clk);
        @(negedge clk);
        chk("deq_timing", 64'(deq_valid), 64'h1);
        wait_start();
        chk("deq_dest_idle", 64'(deq_dest), 64'd0);

        // Two grants in one row, then a grant on an unrequested VOQ.
        expect_ev(K_PROTO, 64'd0);
        expect_ev(K_START, pm(0, 2, 2));
        decide(gm(0, 1) | gm(0, 2));
        @(negedge clk);
        chk("proto_timing", 64'(proto_err), 64'd1);
        wait_start();
        expect_ev(K_PROTO, 64'd0);
        expect_ev(K_START, pm(0, 2, 2));
        decide(gm(1, 0));
        wait_start();

        // Drain [0][2].
        expect_ev(K_DEQ, dq(4'b0001, 8'h02));
        expect_ev(K_START, pm(0, 2, 1));
        decide(gm(0, 2));
        wait_start();
        expect_ev(K_DEQ, dq(4'b0001, 8'h02));
        decide(gm(0, 2));
        repeat (6) @(negedge clk);
        chk("drained_pri", pri_req, 64'd0);
        chk("drained_nostart", 64'(start), 64'd0);

        // Starvation on [1][3]: eight empty decisions, then forced to P-1.
        for (int r = 0; r < 8; r++) expect_ev(K_START, pm(1, 3, 1));
        expect_ev(K_START, pm(1, 3, 15));
        arr_valid[1] = 1'b1;
        arr_dest[1]  = 2'd3;
        @(negedge clk);
        arr_valid[1] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            wait_start();
            decide('0);
        end
        wait_start();
        chk("starve_pri", 64'(pri_req[1][3]), 64'd15);
        expect_ev(K_DEQ, dq(4'b0010, 8'h0C));
        decide(gm(1, 3));
        repeat (6) @(negedge clk);
        chk("starve_cleared", pri_req, 64'd0);

        // Fill [2][0] to DEPTH and keep pushing.
        expect_ev(K_START, pm(2, 0, 1));
        expect_ev(K_TMO, 64'd0);
        expect_ev(K_START, pm(2, 0, 15));
        expect_ev(K_DEQ, dq(4'b0100, 8'h00));
        expect_ev(K_START, pm(2, 0, 14));
        arr_valid[2] = 1'b1;
        arr_dest[2]  = 2'd0;
        repeat (15) @(negedge clk);
        chk("full_ready", 64'(arr_ready), 64'hb);
        repeat (3) @(negedge clk);
        chk("full_hold", 64'(arr_ready), 64'hb);
        arr_valid[2] = 1'b0;
        arr_dest[2]  = 2'd1;
        #1;
        chk("other_ready", 64'(arr_ready), 64'hf);
        arr_dest[2] = 2'd0;
        wait_timeout();
        @(negedge clk);
        chk("full_restart", 64'(start), 64'd1);
        decide(gm(2, 0));
        @(negedge clk);
        chk("apply_ready", 64'(arr_ready), 64'hb);
        @(negedge clk);
        chk("after_deq_ready", 64'(arr_ready), 64'hf);
        wait_start();

        // Reset in WAIT, then a stray decision in IDLE.
        reset = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
        reset          = 1'b0;
        decision       = gm(2, 0);
        decision_valid = 1'b1;
        @(negedge clk);
        decision_valid = 1'b0;
        decision       = '0;
        repeat (10) @(negedge clk);
        chk("midrst_nodeq", 64'(deq_valid), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
